// File: rtl/perf_event_gen_pkg.sv
// perf_event_gen_pkg
//   Shared definitions for the performance event generator and the counter
//   unit that consumes its events: event selector codes (bit positions on
//   the event bus), RISC-V major opcodes used by the decoder, the trap
//   tracking state type and the misaligned-access helper.
package perf_event_gen_pkg;

    // Event selector codes; each value is also the bit index on the event bus.
    localparam int unsigned LOAD_INSTRUCTIONS  = 1;
    localparam int unsigned STORE_INSTRUCTIONS = 2;
    localparam int unsigned UNALIGNED_ACCESSES = 3;
    localparam int unsigned ARITH_INSTRUCTIONS = 4;
    localparam int unsigned TRAPS_TAKEN        = 5;
    localparam int unsigned INTERRUPTS_TAKEN   = 6;
    localparam int unsigned UNCOND_BRANCHES    = 7;
    localparam int unsigned COND_BRANCHES      = 8;
    localparam int unsigned TAKEN_BRANCHS      = 9;

    // Major opcodes, retire_instr[6:0].
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_TRAP = 2'd1,
        IN_IRQ  = 2'd2
    } trap_state_t;

    // Access size comes from funct3[1:0]; size code 3 is treated as a word.
    function automatic logic is_unaligned(input logic [1:0] size, input logic [1:0] addr);
        logic res;
        case (size)
            2'b00:   res = 1'b0;
            2'b01:   res = addr[0];
            default: res = |addr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/perf_event_gen_if.sv
// EVENT_INT
//   Event bus from the event generator to the counter unit.
//   execute : one retired instruction in this cycle
//   events  : one-cycle event pulses, bit index = event selector code
interface EVENT_INT #(
    parameter int EVENT_W = 16
) ();
    logic               execute;
    logic [EVENT_W-1:0] events;

    modport out  (output execute, output events);
    modport sink (input  execute, input  events);
endinterface

// File: rtl/perf_event_gen_classify.sv
// perf_instr_classify
//   Purely combinational classification of one retiring instruction into
//   the retire-side event bits (load, store, unaligned, arith, branches).
//   Trap bits and bit 0 are always driven 0 here.
//   Ports: valid     - instruction retires this cycle
//          instr     - instruction word
//          addr      - effective address low bits (load/store only)
//          br_taken  - conditional branch resolved taken
//          events    - event vector, bit index = selector code
module perf_instr_classify
    import perf_event_gen_pkg::*;
#(
    parameter int EVENT_W = 16
) (
    input  logic               valid,
    input  logic [31:0]        instr,
    input  logic [1:0]         addr,
    input  logic               br_taken,
    output logic [EVENT_W-1:0] events
);

    logic [6:0] opcode;
    logic [1:0] size;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign size   = instr[13:12];
    assign unused_instr_bits = ^{instr[31:14], instr[11:7]};

    always_comb begin
        events = '0;
        if (valid) begin
            case (opcode)
                OPC_LOAD: begin
                    events[LOAD_INSTRUCTIONS]  = 1'b1;
                    events[UNALIGNED_ACCESSES] = is_unaligned(size, addr);
                end
                OPC_STORE: begin
                    events[STORE_INSTRUCTIONS] = 1'b1;
                    events[UNALIGNED_ACCESSES] = is_unaligned(size, addr);
                end
                OPC_OP, OPC_OPIMM: events[ARITH_INSTRUCTIONS] = 1'b1;
                OPC_JAL, OPC_JALR: events[UNCOND_BRANCHES]    = 1'b1;
                OPC_BRANCH: begin
                    events[COND_BRANCHES] = 1'b1;
                    events[TAKEN_BRANCHS] = br_taken;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/perf_event_gen.sv
// perf_event_gen
//   Turns retire and trap activity into registered one-cycle event pulses
//   for the performance counter unit. A trap tracking FSM makes a trap
//   entry sequence that holds trap_taken for several cycles count once.
//   Ports: clk, rst (async, active low)
//          retire_valid/instr/mem_addr/br_taken - retiring instruction
//          trap_taken, trap_is_irq              - trap entry and its cause
//          mret_retired                         - MRET completed (with retire_valid)
//          event_bus                            - execute + events[EVENT_W-1:0]
module perf_event_gen
    import perf_event_gen_pkg::*;
#(
    parameter int EVENT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_valid,
    input  logic [31:0] retire_instr,
    input  logic [1:0]  retire_mem_addr,
    input  logic        retire_br_taken,
    input  logic        trap_taken,
    input  logic        trap_is_irq,
    input  logic        mret_retired,
    EVENT_INT.out       event_bus
);

    trap_state_t        state_q, state_d;
    logic               trap_q, trap_d;
    logic               execute_q, execute_d;
    logic [EVENT_W-1:0] events_q, events_d;
    logic [EVENT_W-1:0] retire_events;
    logic               trap_pulse, irq_pulse;
    logic               mret_ok;

    perf_instr_classify #(.EVENT_W(EVENT_W)) u_classify (
        .valid    (retire_valid),
        .instr    (retire_instr),
        .addr     (retire_mem_addr),
        .br_taken (retire_br_taken),
        .events   (retire_events)
    );

    assign mret_ok = mret_retired & retire_valid;

    // Trap FSM: pulse on entry from IDLE, or on a fresh 0->1 of trap_taken
    // while still inside a previous trap (nested trap).
    always_comb begin
        state_d    = state_q;
        trap_pulse = 1'b0;
        irq_pulse  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap_taken) begin
                    trap_pulse = 1'b1;
                    irq_pulse  = trap_is_irq;
                    state_d    = trap_is_irq ? IN_IRQ : IN_TRAP;
                end
            end
            IN_TRAP, IN_IRQ: begin
                if (!trap_taken || mret_ok) begin
                    state_d = IDLE;
                end else if (!trap_q) begin
                    trap_pulse = 1'b1;
                    irq_pulse  = trap_is_irq;
                    state_d    = trap_is_irq ? IN_IRQ : IN_TRAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trap_d    = trap_taken;
        execute_d = retire_valid;
        events_d  = retire_events;
        events_d[TRAPS_TAKEN]      = trap_pulse;
        events_d[INTERRUPTS_TAKEN] = irq_pulse;
        events_d[0]                = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            trap_q    <= 1'b0;
            execute_q <= 1'b0;
            events_q  <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            execute_q <= execute_d;
            events_q  <= events_d;
        end
    end

    assign event_bus.execute = execute_q;
    assign event_bus.events  = events_q;

endmodule

// File: tb/tb_perf_event_gen.sv
module tb_perf_event_gen;
    import perf_event_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_instr = '0;
    logic [1:0]  retire_mem_addr = '0;
    logic        retire_br_taken = 1'b0;
    logic        trap_taken = 1'b0;
    logic        trap_is_irq = 1'b0;
    logic        mret_retired = 1'b0;

    int checks = 0;
    int errors = 0;

    EVENT_INT #(.EVENT_W(16)) bus ();

    perf_event_gen #(.EVENT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .retire_valid    (retire_valid),
        .retire_instr    (retire_instr),
        .retire_mem_addr (retire_mem_addr),
        .retire_br_taken (retire_br_taken),
        .trap_taken      (trap_taken),
        .trap_is_irq     (trap_is_irq),
        .mret_retired    (mret_retired),
        .event_bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [1:0]  addr;
        logic        br;
        logic        exp_exec;
        logic [15:0] exp_ev;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [31:0] i, input logic [1:0] a,
                                input logic b, input logic ee, input logic [15:0] ev,
                                input string n);
        vec_t r;
        r.valid = v; r.instr = i; r.addr = a; r.br = b;
        r.exp_exec = ee; r.exp_ev = ev; r.name = n;
        return r;
    endfunction

    function automatic logic [16:0] outv();
        return {bus.execute, bus.events};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one input cycle right after a negedge, then move to the next
    // negedge so the registered result of that cycle is visible.
    task automatic apply(input logic v, input logic [31:0] i, input logic [1:0] a,
                         input logic b, input logic t, input logic irq, input logic m);
        retire_valid = v; retire_instr = i; retire_mem_addr = a; retire_br_taken = b;
        trap_taken = t; trap_is_irq = irq; mret_retired = m;
        @(negedge clk);
    endtask

    // Reference: retire events straight from the instruction-set rules.
    function automatic logic [15:0] model_retire(input logic v, input logic [31:0] instr,
                                                 input logic [1:0] addr, input logic br);
        logic [15:0] e;
        int          bytes;
        int          a;
        e = '0;
        if (!v) return e;
        case (instr[6:0])
            7'h03: e[1] = 1'b1;
            7'h23: e[2] = 1'b1;
            7'h33, 7'h13: e[4] = 1'b1;
            7'h6f, 7'h67: e[7] = 1'b1;
            7'h63: begin e[8] = 1'b1; e[9] = br; end
            default: ;
        endcase
        if (e[1] || e[2]) begin
            bytes = (instr[13:12] == 2'd3) ? 4 : (1 << instr[13:12]);
            a = int'(addr);
            e[3] = (a % bytes) != 0;
        end
        return e;
    endfunction

    logic [6:0] opcs [9];

    initial begin
        logic [16:0] exp_q;
        bit          have;
        bit          active;
        logic        v, b, t, irq, m, p;
        logic [31:0] ins;
        logic [1:0]  ad;
        logic [15:0] ev;

        opcs = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6f, 7'h67, 7'h63, 7'h37, 7'h17};

        vecs.push_back(mk(1, 32'h0000A083, 2'b10, 0, 1, 16'h000A, "lw_addr10"));
        vecs.push_back(mk(0, 32'h00000000, 2'b00, 0, 0, 16'h0000, "idle_after_lw"));
        vecs.push_back(mk(1, 32'h0000A083, 2'b00, 0, 1, 16'h0002, "lw_aligned"));
        vecs.push_back(mk(1, 32'h00001083, 2'b01, 0, 1, 16'h000A, "lh_addr01"));
        vecs.push_back(mk(1, 32'h00001083, 2'b10, 0, 1, 16'h0002, "lh_addr10"));
        vecs.push_back(mk(1, 32'h00000083, 2'b11, 0, 1, 16'h0002, "lb_addr11"));
        vecs.push_back(mk(1, 32'h00002023, 2'b01, 0, 1, 16'h000C, "sw_addr01"));
        vecs.push_back(mk(1, 32'h00003003, 2'b10, 0, 1, 16'h000A, "f3_11_addr10"));
        vecs.push_back(mk(1, 32'h00208033, 2'b01, 1, 1, 16'h0010, "add"));
        vecs.push_back(mk(1, 32'h00100093, 2'b00, 0, 1, 16'h0010, "addi"));
        vecs.push_back(mk(1, 32'h0000006F, 2'b00, 1, 1, 16'h0080, "jal_br_ignored"));
        vecs.push_back(mk(1, 32'h00008067, 2'b00, 0, 1, 16'h0080, "jalr"));
        vecs.push_back(mk(1, 32'h00208463, 2'b00, 1, 1, 16'h0300, "beq_taken"));
        vecs.push_back(mk(1, 32'h00208463, 2'b00, 0, 1, 16'h0100, "beq_not_taken"));
        vecs.push_back(mk(0, 32'h0000A083, 2'b10, 0, 0, 16'h0000, "lw_not_valid"));
        vecs.push_back(mk(1, 32'h000000B7, 2'b00, 0, 1, 16'h0000, "lui_no_event"));

        // Reset held while a load retires: nothing may come out.
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            apply(1, 32'h0000A083, 2'b00, 0, 0, 0, 0);
            check("reset_hold", outv(), 17'h0);
        end
        check("reset_state", {15'd0, dut.state_q}, {15'd0, IDLE});
        rst = 1'b1;
        apply(1, 32'h0000A083, 2'b00, 0, 0, 0, 0);
        check("first_after_reset", outv(), {1'b1, 16'h0002});

        foreach (vecs[k]) begin
            apply(vecs[k].valid, vecs[k].instr, vecs[k].addr, vecs[k].br, 0, 0, 0);
            check(vecs[k].name, outv(), {vecs[k].exp_exec, vecs[k].exp_ev});
        end

        // Interrupt held for 4 cycles counts once.
        apply(0, 0, 0, 0, 1, 1, 0);
        check("irq_first", outv(), {1'b0, 16'h0060});
        check("irq_state", {15'd0, dut.state_q}, {15'd0, IN_IRQ});
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 0, 0, 1, 1, 0);
            check("irq_held", outv(), 17'h0);
        end
        apply(0, 0, 0, 0, 0, 0, 0);
        check("irq_drop", outv(), 17'h0);
        check("irq_back_idle", {15'd0, dut.state_q}, {15'd0, IDLE});

        // Retire and trap entry in the same cycle.
        apply(1, 32'h00100093, 0, 0, 1, 0, 0);
        check("addi_plus_trap", outv(), {1'b1, 16'h0030});
        apply(0, 0, 0, 0, 0, 0, 0);
        check("addi_trap_clear", outv(), 17'h0);

        // Nested trap: short gap, no MRET.
        apply(0, 0, 0, 0, 1, 0, 0);
        check("nest_first", outv(), {1'b0, 16'h0020});
        apply(0, 0, 0, 0, 0, 0, 0);
        check("nest_gap", outv(), 17'h0);
        apply(0, 0, 0, 0, 1, 0, 0);
        check("nest_second", outv(), {1'b0, 16'h0020});
        apply(0, 0, 0, 0, 1, 0, 0);
        check("nest_held", outv(), 17'h0);
        apply(0, 0, 0, 0, 0, 0, 0);

        // MRET leaves the trap state.
        apply(0, 0, 0, 0, 1, 0, 0);
        check("mret_trap", outv(), {1'b0, 16'h0020});
        apply(1, 32'h30200073, 0, 0, 1, 0, 1);
        check("mret_retire", outv(), {1'b1, 16'h0000});
        check("mret_idle", {15'd0, dut.state_q}, {15'd0, IDLE});
        apply(0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a trap; trap still high afterwards counts once.
        apply(0, 0, 0, 0, 1, 0, 0);
        check("rst_mid_trap", outv(), {1'b0, 16'h0020});
        rst = 1'b0;
        apply(0, 0, 0, 0, 1, 0, 0);
        check("rst_mid_hold", outv(), 17'h0);
        rst = 1'b1;
        apply(0, 0, 0, 0, 1, 0, 0);
        check("rst_release_once", outv(), {1'b0, 16'h0020});
        apply(0, 0, 0, 0, 1, 0, 0);
        check("rst_release_held", outv(), 17'h0);
        apply(0, 0, 0, 0, 0, 0, 0);

        // Random traffic against the reference model, from a clean reset.
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        have = 0; active = 0; t = 0;
        for (int i = 0; i < 500; i++) begin
            if (have) check("random", outv(), exp_q);
            v   = $urandom_range(0, 3) != 0;
            ins = $urandom();
            ins[6:0] = opcs[$urandom_range(0, 8)];
            ad  = 2'($urandom_range(0, 3));
            b   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) t = ~t;
            irq = $urandom_range(0, 1) == 1;
            m   = v && ($urandom_range(0, 7) == 0);
            retire_valid = v; retire_instr = ins; retire_mem_addr = ad; retire_br_taken = b;
            trap_taken = t; trap_is_irq = irq; mret_retired = m;
            // A trap episode begins when trap_taken is seen outside an
            // episode; it lasts while trap_taken stays high and no MRET retires.
            ev = model_retire(v, ins, ad, b);
            p  = t && !active;
            ev[5] = p;
            ev[6] = p && irq;
            exp_q = {v, ev};
            active = p || (active && t && !(m && v));
            have = 1;
            @(negedge clk);
        end
        check("random", outv(), exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
